// File: rtl/pc_stack.sv
// pc_stack: program counter with return-address stack (optional PC_STACK_CIRCULAR_EN overwrites oldest entry on overflow)
module pc_stack #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [DW:0] SUM_DEPTH = (DW + 1)'(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [PW-1:0]    base;
    logic [DW:0]      push_sum, pop_sum;
    logic [PW-1:0]    push_idx, pop_idx;
    logic             do_call, push_en;

`ifndef PC_STACK_CIRCULAR_EN
    assign base = '0;
`endif

    // Map logical stack positions onto physical slots relative to the base pointer
    always_comb begin
        push_sum = {1'b0, depth} + (DW + 1)'(base);
        push_idx = PW'(push_sum >= SUM_DEPTH ? push_sum - SUM_DEPTH : push_sum);
        pop_sum  = push_sum - (DW + 1)'(1);
        pop_idx  = PW'(pop_sum >= SUM_DEPTH ? pop_sum - SUM_DEPTH : pop_sum);
        do_call  = !reset && !load && call;
`ifdef PC_STACK_CIRCULAR_EN
        push_en  = do_call;
`else
        push_en  = do_call && !full;
`endif
    end

    // Stack storage; kept reset-free so it can map onto a plain register file
    always_ff @(posedge clk) begin
        if (push_en)
            stack[push_idx] <= out + WIDTH'(1);
    end

    // PC, depth and status registers with strict control priority
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= RESET_VEC;
            depth     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef PC_STACK_CIRCULAR_EN
            base      <= '0;
`endif
        end else if (load) begin
            out <= in;
        end else if (call) begin
            out <= in;
            if (full) begin
                overflow <= 1'b1;
`ifdef PC_STACK_CIRCULAR_EN
                base     <= base == PW'(DEPTH - 1) ? '0 : base + PW'(1);
`endif
            end else begin
                depth <= depth + DW'(1);
                empty <= 1'b0;
                full  <= depth == DW'(DEPTH - 1);
            end
        end else if (ret) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                out   <= stack[pop_idx];
                depth <= depth - DW'(1);
                empty <= depth == DW'(1);
                full  <= 1'b0;
            end
        end else if (inc) begin
            out <= out + WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed scoreboard bench for pc_stack (DEPTH=2, RESET_VEC=0x0100)
module tb_pc_stack;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, load, inc, call, ret;
    logic [15:0] in;
    logic [15:0] out;
    logic [1:0]  depth;
    logic        empty, full, overflow, underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] o;
        logic [1:0]  d;
        logic        e, f, ov, un;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_out;
    logic [15:0] m_stk[$];
    logic        m_ov, m_un;

    pc_stack #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VEC(16'h0100)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .call(call), .ret(ret),
        .out(out), .depth(depth), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of controls, advance the reference model, then compare after the edge
    task automatic step(input string tag, input logic r, l, i, c, rt, input logic [15:0] d);
        exp_t e;
        reset = r; load = l; inc = i; call = c; ret = rt; in = d;
        if (r) begin
            m_out = 16'h0100; m_stk.delete(); m_ov = 0; m_un = 0;
        end else if (l) begin
            m_out = d;
        end else if (c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_out + 16'd1);
            else begin
                m_ov = 1;
`ifdef PC_STACK_CIRCULAR_EN
                void'(m_stk.pop_front());
                m_stk.push_back(m_out + 16'd1);
`endif
            end
            m_out = d;
        end else if (rt) begin
            if (m_stk.size() == 0) m_un = 1;
            else m_out = m_stk.pop_back();
        end else if (i) begin
            m_out = m_out + 16'd1;
        end
        e.o = m_out; e.d = 2'(m_stk.size()); e.e = m_stk.size() == 0;
        e.f = m_stk.size() == DEPTH; e.ov = m_ov; e.un = m_un;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_out"}, out, e.o);
            chk({tag, "_depth"}, 16'(depth), 16'(e.d));
            chk({tag, "_empty"}, 16'(empty), 16'(e.e));
            chk({tag, "_full"}, 16'(full), 16'(e.f));
            chk({tag, "_ovf"}, 16'(overflow), 16'(e.ov));
            chk({tag, "_unf"}, 16'(underflow), 16'(e.un));
        end
    endtask

    initial begin
        m_out = 16'h0; m_ov = 0; m_un = 0;
        reset = 1; load = 0; inc = 0; call = 0; ret = 0; in = '0;
        #1;
        step("rst", 1, 0, 0, 0, 0, 16'h0);
        chk("rst_vec", out, 16'h0100);
        chk("rst_empty", 16'(empty), 16'd1);
        step("inc1", 0, 0, 1, 0, 0, 16'h0);
        chk("inc1_v", out, 16'h0101);
        step("inc2", 0, 0, 1, 0, 0, 16'h0);
        step("inc3", 0, 0, 1, 0, 0, 16'h0);
        chk("inc3_v", out, 16'h0103);
        step("ld_ffff", 0, 1, 0, 0, 0, 16'hFFFF);
        step("wrap", 0, 0, 1, 0, 0, 16'h0);
        chk("wrap_v", out, 16'h0000);
        step("prio", 0, 1, 1, 1, 0, 16'h1234);
        chk("prio_v", out, 16'h1234);
        chk("prio_depth", 16'(depth), 16'd0);
        step("ld_10", 0, 1, 0, 0, 0, 16'h0010);
        step("call200", 0, 0, 0, 1, 0, 16'h0200);
        step("call300", 0, 0, 0, 1, 0, 16'h0300);
        chk("nest_depth", 16'(depth), 16'd2);
        step("ret1", 0, 0, 0, 0, 1, 16'h0);
        chk("ret1_v", out, 16'h0201);
        step("ret2", 0, 0, 0, 0, 1, 16'h0);
        chk("ret2_v", out, 16'h0011);
        step("callret", 0, 0, 0, 1, 1, 16'h0500);
        chk("callret_v", out, 16'h0500);
        step("ret3", 0, 0, 0, 0, 1, 16'h0);
        chk("ret3_v", out, 16'h0012);
        step("ld_x10", 0, 1, 0, 0, 0, 16'h0010);
        step("oc1", 0, 0, 0, 1, 0, 16'h0020);
        step("oc2", 0, 0, 0, 1, 0, 16'h0030);
        step("ldcall_full", 0, 1, 0, 1, 0, 16'h0030);
        chk("ldcall_noovf", 16'(overflow), 16'd0);
        step("oc3", 0, 0, 0, 1, 0, 16'h0040);
        chk("ovf_v", 16'(overflow), 16'd1);
        chk("ovf_pc", out, 16'h0040);
        step("or1", 0, 0, 0, 0, 1, 16'h0);
`ifdef PC_STACK_CIRCULAR_EN
        chk("or1_v", out, 16'h0031);
`else
        chk("or1_v", out, 16'h0021);
`endif
        step("or2", 0, 0, 0, 0, 1, 16'h0);
`ifdef PC_STACK_CIRCULAR_EN
        chk("or2_v", out, 16'h0021);
`else
        chk("or2_v", out, 16'h0011);
`endif
        step("ld_42", 0, 1, 0, 0, 0, 16'h0042);
        step("unf", 0, 0, 0, 0, 1, 16'h0);
        chk("unf_pc", out, 16'h0042);
        for (int k = 0; k < 5; k++) step("idle", 0, 0, 0, 0, 0, 16'h0);
        chk("unf_sticky", 16'(underflow), 16'd1);
        step("rst2", 1, 0, 0, 0, 0, 16'h0);
        chk("rst2_unf", 16'(underflow), 16'd0);
        step("fc1", 0, 0, 0, 1, 0, 16'h0001);
        step("fc2", 0, 0, 0, 1, 0, 16'h0002);
        step("rst_full", 1, 0, 0, 1, 0, 16'h0003);
        chk("rstf_full", 16'(full), 16'd0);
        chk("rstf_pc", out, 16'h0100);
        step("ret_after_rst", 0, 0, 0, 0, 1, 16'h0);
        step("inc_end", 0, 0, 1, 0, 0, 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated return-address stack for the CPU fetch path. Keeps the classic reset/load/increment behaviour, adds `call` (jump and push the return address) and `ret` (pop and jump), and exposes stack depth and error status. Drives the instruction-memory address directly; all outputs are registered.

## Interface

**Parameters**
- `WIDTH`, 16: counter and address width in bits.
- `DEPTH`, 8: number of return-stack entries, at least 2.
- `RESET_VEC`, 0: value loaded into `out` on reset.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in` in WIDTH: jump or call target.
- `load` in 1: jump to `in`.
- `inc` in 1: advance by 1.
- `call` in 1: push `out+1`, then jump to `in`.
- `ret` in 1: pop the top entry into `out`.
- `out` out WIDTH: current PC.
- `depth` out $clog2(DEPTH+1): number of valid stack entries.
- `empty` out 1: `depth == 0`.
- `full` out 1: `depth == DEPTH`.
- `overflow` out 1: sticky; set by a `call` while full.
- `underflow` out 1: sticky; set by a `ret` while empty.

## Operation

Controls are sampled on each rising edge. Priority is strict, and only the highest-priority asserted control acts:

1. `reset`
   - `out` ← RESET_VEC.
   - `depth` ← 0.
   - `overflow` and `underflow` ← 0.
   - Stack contents are don't-care.
2. `load`
   - `out` ← `in`.
   - Stack untouched.
3. `call`
   - Push `out+1`, computed modulo 2^WIDTH, as the new top.
   - `depth` +1.
   - `out` ← `in`.
4. `ret`
   - `out` ← top entry.
   - `depth` −1.
5. `inc`
   - `out` ← `out+1` modulo 2^WIDTH, so 2^WIDTH−1 wraps to 0.
6. None asserted: hold all state.

Boundary conditions:
- **`call` while full:** governed by PC_STACK_CIRCULAR_EN (see Configuration).
- **`ret` while empty:** `out` holds, `depth` stays 0, `underflow` ← 1.
- **`call` and `ret` together:** `call` wins. No net-zero pop/push.
- **`load` and `call` together:** pure load. No push, no error flag.
- **Sticky flags:** `overflow` and `underflow` clear only on `reset`.
- **Stack storage:** LIFO array indexed by `depth`. The top is entry `depth−1`.

## Timing

- Every output is a register; there is no combinational path from inputs to outputs.
- Latency is one cycle. A control sampled at edge *t* is visible on `out`, `depth`, flags at *t+1*.
- Back-to-back `call` then `ret` on consecutive cycles returns to the caller's PC+1 on the second cycle after the call.
- Reset values:
  - `out` = RESET_VEC
  - `depth` = 0
  - `empty` = 1
  - `full` = 0
  - `overflow` = 0
  - `underflow` = 0
- Reset asserted mid-sequence, including while full, overrides everything that cycle. Pending stack contents are discarded.

## Configuration

- **PC_STACK_CIRCULAR_EN defined:** a `call` while full still jumps to `in` and pushes `out+1`, overwriting the oldest entry.
  - `depth` stays DEPTH.
  - `overflow` ← 1.
  - Subsequent `ret`s return the newest DEPTH addresses in LIFO order. Storage is a circular buffer with a rotating base pointer.
- **PC_STACK_CIRCULAR_EN undefined:** a `call` while full still jumps (`out` ← `in`), but the push is dropped.
  - `depth` stays DEPTH.
  - Stack contents are unchanged.
  - `overflow` ← 1.

## Test plan

- **Reset and increment:** with RESET_VEC=0x0100, reset for 1 cycle, then `inc` for 3 cycles.
  - `out` = 0x0100 → 0x0101 → 0x0102 → 0x0103.
  - `empty`=1, `depth`=0.
- **Priority and wrap:** `out`=0xFFFF with `inc`.
  - `out` → 0x0000.
  - Then `load`=`inc`=`call`=1 with `in`=0x1234: `out`=0x1234, `depth` remains 0.
- **Nested call/ret:** from `out`=0x0010, call 0x0200, then call 0x0300.
  - `depth`=2, `out`=0x0300.
  - `ret` → `out`=0x0201; `ret` → `out`=0x0011; `empty`=1.
- **Overflow (DEPTH=2):** 3 calls from PCs 0x10, 0x20, 0x30.
  - `full`=1, `overflow`=1.
  - Two `ret`s return 0x21 then 0x11 without the macro, or 0x31 then 0x21 with it.
- **Underflow and reset recovery:** `ret` while empty with `out`=0x0042.
  - `out` stays 0x0042, `underflow`=1, still set 5 cycles later.
  - Reset clears it and `out`=RESET_VEC.
- **Reset while full:** assert `reset` together with `call`.
  - Next cycle: `depth`=0, `full`=0, `out`=RESET_VEC.
